// File: rtl/cva6_axi_sram_responder.sv
// AXI4 subordinate serving one transaction at a time from a single-ported SRAM. Reads and writes take turns.
// Writes run at 1 beat/cycle with B the cycle after the last W; reads take 2 cycles/beat; R is held stable under stall.
module cva6_axi_sram_responder #(
  parameter int unsigned          AddrWidth    = 64,
  parameter int unsigned          DataWidth    = 128,
  parameter int unsigned          IdWidth      = 4,
  parameter int unsigned          UserWidth    = 32,
  parameter logic [AddrWidth-1:0] BaseAddr     = AddrWidth'(64'h8000_0000),
  parameter int unsigned          MemBytes     = 65536,
  parameter int unsigned          MemAddrWidth = $clog2(MemBytes / (DataWidth / 8))
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      aw_valid_i,
  output logic                      aw_ready_o,
  input  logic [IdWidth-1:0]        aw_id_i,
  input  logic [AddrWidth-1:0]      aw_addr_i,
  input  logic [7:0]                aw_len_i,
  input  logic [2:0]                aw_size_i,
  input  logic [1:0]                aw_burst_i,
  input  logic                      w_valid_i,
  output logic                      w_ready_o,
  input  logic [DataWidth-1:0]      w_data_i,
  input  logic [DataWidth/8-1:0]    w_strb_i,
  input  logic                      w_last_i,
  output logic                      b_valid_o,
  input  logic                      b_ready_i,
  output logic [IdWidth-1:0]        b_id_o,
  output logic [1:0]                b_resp_o,
  input  logic                      ar_valid_i,
  output logic                      ar_ready_o,
  input  logic [IdWidth-1:0]        ar_id_i,
  input  logic [AddrWidth-1:0]      ar_addr_i,
  input  logic [7:0]                ar_len_i,
  input  logic [2:0]                ar_size_i,
  input  logic [1:0]                ar_burst_i,
  output logic                      r_valid_o,
  input  logic                      r_ready_i,
  output logic [IdWidth-1:0]        r_id_o,
  output logic [DataWidth-1:0]      r_data_o,
  output logic [1:0]                r_resp_o,
  output logic                      r_last_o,
  output logic [UserWidth-1:0]      r_user_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MemAddrWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]      mem_wdata_o,
  output logic [DataWidth/8-1:0]    mem_be_o,
  input  logic [DataWidth-1:0]      mem_rdata_i
);

  localparam int unsigned          OffBits    = $clog2(DataWidth / 8);
  localparam logic [AddrWidth-1:0] MemSize    = AddrWidth'(MemBytes);
  localparam logic [1:0]           RespOkay   = 2'b00;
  localparam logic [1:0]           RespSlvErr = 2'b10;
  localparam logic [1:0]           BurstFixed = 2'b00;

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RREQ, RRESP} state_e;

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [IdWidth-1:0]     r_id;
  logic [AddrWidth-1:0]   r_addr;
  logic [7:0]             r_len;
  logic [2:0]             r_size;
  logic [1:0]             r_burst;
  logic                   r_err;
  logic [7:0]             r_cnt;
  logic                   r_last_wr;

  logic [AddrWidth-1:0]   w_off;
  logic [AddrWidth-1:0]   w_step;
  logic [AddrWidth-1:0]   w_addr_nxt;
  logic                   w_in_range;
  logic                   w_beat_err;
  logic                   w_last_beat;
  logic                   w_aw_gnt;
  logic                   w_ar_gnt;
  logic                   w_adv;
  logic                   w_err_set;
  logic [MemAddrWidth-1:0] w_mem_addr;

  assign w_off       = r_addr - BaseAddr;
  assign w_in_range  = (r_addr >= BaseAddr) && (w_off < MemSize);
  assign w_beat_err  = r_err || !w_in_range;
  assign w_last_beat = (r_cnt == r_len);
  assign w_step      = AddrWidth'(1) << r_size;
  assign w_addr_nxt  = (r_burst == BurstFixed) ? r_addr
                                               : ((r_addr & ~(w_step - AddrWidth'(1))) + w_step);
  assign w_mem_addr  = MemAddrWidth'(w_off >> OffBits);
  // On a conflict the type not served last wins; r_last_wr resets to "write" so reads win first.
  assign w_aw_gnt    = aw_valid_i && (!ar_valid_i || !r_last_wr);
  assign w_ar_gnt    = ar_valid_i && (!aw_valid_i || r_last_wr);
  assign r_user_o    = '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_adv       = 1'b0;
    w_err_set   = 1'b0;
    aw_ready_o  = 1'b0;
    ar_ready_o  = 1'b0;
    w_ready_o   = 1'b0;
    b_valid_o   = 1'b0;
    b_id_o      = '0;
    b_resp_o    = RespOkay;
    r_valid_o   = 1'b0;
    r_id_o      = '0;
    r_data_o    = '0;
    r_resp_o    = RespOkay;
    r_last_o    = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    case (r_state)
      IDLE: begin
        // Readies are gated by reset so every output is low while rst_ni is asserted.
        aw_ready_o = w_aw_gnt && rst_ni;
        ar_ready_o = w_ar_gnt && rst_ni;
        if (w_aw_gnt) begin
          w_state_nxt = WRITE;
        end else if (w_ar_gnt) begin
          w_state_nxt = RREQ;
        end
      end
      WRITE: begin
        w_ready_o = 1'b1;
        if (w_valid_i) begin
          if (!w_beat_err) begin
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = w_mem_addr;
            mem_wdata_o = w_data_i;
            mem_be_o    = w_strb_i;
          end
          if (!w_in_range || (w_last_i != w_last_beat)) begin
            w_err_set = 1'b1;
          end
          if (w_last_beat) begin
            w_state_nxt = WRESP;
          end else begin
            w_adv = 1'b1;
          end
        end
      end
      WRESP: begin
        b_valid_o = 1'b1;
        b_id_o    = r_id;
        b_resp_o  = r_err ? RespSlvErr : RespOkay;
        if (b_ready_i) begin
          w_state_nxt = IDLE;
        end
      end
      RREQ: begin
        if (!w_beat_err) begin
          mem_req_o  = 1'b1;
          mem_addr_o = w_mem_addr;
        end
        w_state_nxt = RRESP;
      end
      RRESP: begin
        // The macro holds rdata until the next request, so R stays stable while stalled.
        r_valid_o = 1'b1;
        r_id_o    = r_id;
        r_data_o  = w_beat_err ? '0 : mem_rdata_i;
        r_resp_o  = w_beat_err ? RespSlvErr : RespOkay;
        r_last_o  = w_last_beat;
        if (r_ready_i) begin
          if (w_last_beat) begin
            w_state_nxt = IDLE;
          end else begin
            w_adv       = 1'b1;
            w_state_nxt = RREQ;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_last_wr <= 1'b1;
    end else begin
      if (r_state == IDLE) begin
        if (w_aw_gnt) begin
          r_id      <= aw_id_i;
          r_addr    <= aw_addr_i;
          r_len     <= aw_len_i;
          r_size    <= aw_size_i;
          r_burst   <= aw_burst_i;
          r_err     <= aw_burst_i[1];
          r_cnt     <= '0;
          r_last_wr <= 1'b1;
        end else if (w_ar_gnt) begin
          r_id      <= ar_id_i;
          r_addr    <= ar_addr_i;
          r_len     <= ar_len_i;
          r_size    <= ar_size_i;
          r_burst   <= ar_burst_i;
          r_err     <= ar_burst_i[1];
          r_cnt     <= '0;
          r_last_wr <= 1'b0;
        end
      end
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_adv) begin
        r_cnt  <= r_cnt + 8'd1;
        r_addr <= w_addr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cva6_axi_sram_responder.sv
// Directed bench for cva6_axi_sram_responder with a behavioural SRAM behind the memory port.
module tb_cva6_axi_sram_responder;

  localparam logic [1:0] INCR = 2'b01;
  localparam logic [1:0] WRAP = 2'b10;
  localparam logic [1:0] OKAY = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [127:0] D_A5 = {16{8'hA5}};
  localparam logic [127:0] D_5A = {16{8'h5A}};
  localparam logic [127:0] D_MERGED = {64'hC0DE0002_C0DE0002, 64'h33333333_33333333};

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  logic aw_valid_i, aw_ready_o, w_valid_i, w_ready_o, w_last_i, b_valid_o, b_ready_i;
  logic ar_valid_i, ar_ready_o, r_valid_o, r_ready_i, r_last_o;
  logic mem_req_o, mem_we_o;
  logic [3:0] aw_id_i, ar_id_i, b_id_o, r_id_o;
  logic [63:0] aw_addr_i, ar_addr_i;
  logic [7:0] aw_len_i, ar_len_i;
  logic [2:0] aw_size_i, ar_size_i;
  logic [1:0] aw_burst_i, ar_burst_i, b_resp_o, r_resp_o;
  logic [127:0] w_data_i, r_data_o, mem_wdata_o, mem_rdata;
  logic [15:0] w_strb_i, mem_be_o;
  logic [31:0] r_user_o;
  logic [11:0] mem_addr_o;
  logic [127:0] mem [0:4095];

  cva6_axi_sram_responder dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i), .aw_addr_i(aw_addr_i),
    .aw_len_i(aw_len_i), .aw_size_i(aw_size_i), .aw_burst_i(aw_burst_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i), .w_strb_i(w_strb_i),
    .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i), .ar_addr_i(ar_addr_i),
    .ar_len_i(ar_len_i), .ar_size_i(ar_size_i), .ar_burst_i(ar_burst_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o), .r_data_o(r_data_o),
    .r_resp_o(r_resp_o), .r_last_o(r_last_o), .r_user_o(r_user_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata)
  );

  // SRAM macro: byte-enabled writes, read data one cycle after the request and held until the next one.
  always @(posedge clk_i) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 16; b++) begin
          if (mem_be_o[b]) mem[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
        end
      end else begin
        mem_rdata <= mem[mem_addr_o];
      end
    end
  end

  logic [47:0] outs_vec;
  assign outs_vec = {aw_ready_o, w_ready_o, b_valid_o, b_id_o, b_resp_o, ar_ready_o, r_valid_o,
                     r_id_o, r_resp_o, r_last_o, mem_req_o, mem_we_o, mem_addr_o, mem_be_o};

  int n_pass = 0;
  int n_fail = 0;
  int n_checks = 0;
  int both_rdy = 0;

  always @(negedge clk_i) begin
    if (aw_ready_o && ar_ready_o) both_rdy++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All tasks are entered 1 time unit after a rising edge, drive there, and sample one unit later.
  task automatic send_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int i = 0;
    aw_valid_i = 1'b1; aw_id_i = id; aw_addr_i = addr; aw_len_i = len;
    aw_size_i = 3'd4; aw_burst_i = burst;
    #1;
    while (!aw_ready_o && i < 20) begin @(posedge clk_i); #2; i++; end
    check("aw_ready", 128'(aw_ready_o), 128'(1));
    @(posedge clk_i); #1;
    aw_valid_i = 1'b0;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    int i = 0;
    ar_valid_i = 1'b1; ar_id_i = id; ar_addr_i = addr; ar_len_i = len;
    ar_size_i = 3'd4; ar_burst_i = burst;
    #1;
    while (!ar_ready_o && i < 20) begin @(posedge clk_i); #2; i++; end
    check("ar_ready", 128'(ar_ready_o), 128'(1));
    @(posedge clk_i); #1;
    ar_valid_i = 1'b0;
  endtask

  task automatic w_beat(input logic [127:0] data, input logic [15:0] strb, input logic last,
                        input int exp_req, input logic [11:0] exp_addr);
    w_valid_i = 1'b1; w_data_i = data; w_strb_i = strb; w_last_i = last;
    #1;
    check("w_ready", 128'(w_ready_o), 128'(1));
    if (exp_req >= 0) check("w_mem_req", 128'(mem_req_o), 128'(exp_req[0]));
    if (exp_req == 1) begin
      check("w_mem_ctl", 128'({mem_we_o, mem_addr_o, mem_be_o}), 128'({1'b1, exp_addr, strb}));
      check("w_mem_wdata", mem_wdata_o, data);
    end
    @(posedge clk_i); #1;
    w_valid_i = 1'b0; w_last_i = 1'b0;
  endtask

  task automatic get_b(input logic [3:0] id, input logic [1:0] resp);
    #1;
    check("b_valid", 128'(b_valid_o), 128'(1));
    check("b_id_resp", 128'({b_id_o, b_resp_o}), 128'({id, resp}));
    b_ready_i = 1'b1;
    @(posedge clk_i); #1;
    b_ready_i = 1'b0;
  endtask

  // Entered with the DUT in RREQ; R must appear exactly one cycle later.
  task automatic get_r(input logic [3:0] id, input logic [127:0] data, input logic [1:0] resp,
                       input logic last, input int stall, input logic exp_req,
                       input logic [11:0] exp_addr);
    #1;
    check("rreq_r_valid", 128'(r_valid_o), 128'(0));
    check("rreq_mem_req", 128'(mem_req_o), 128'(exp_req));
    if (exp_req) check("rreq_mem_cmd", 128'({mem_we_o, mem_addr_o}), 128'({1'b0, exp_addr}));
    @(posedge clk_i); #2;
    check("r_valid", 128'(r_valid_o), 128'(1));
    for (int s = 0; s < stall; s++) begin
      check("r_stall_data", r_data_o, data);
      check("r_stall_ctl", 128'({r_valid_o, r_id_o, r_resp_o, r_last_o}), 128'({1'b1, id, resp, last}));
      @(posedge clk_i); #2;
    end
    check("r_data", r_data_o, data);
    check("r_ctl", 128'({r_id_o, r_resp_o, r_last_o, r_user_o}), 128'({id, resp, last, 32'h0}));
    r_ready_i = 1'b1;
    @(posedge clk_i); #1;
    r_ready_i = 1'b0;
  endtask

  initial begin
    logic [127:0] dk;
    for (int i = 0; i < 4096; i++) mem[i] <= {4{32'hC0DE_0000 | 32'(i)}};
    aw_valid_i = 0; aw_id_i = 0; aw_addr_i = 0; aw_len_i = 0; aw_size_i = 0; aw_burst_i = 0;
    w_valid_i = 0; w_data_i = 0; w_strb_i = 0; w_last_i = 0; b_ready_i = 0;
    ar_valid_i = 0; ar_id_i = 0; ar_addr_i = 0; ar_len_i = 0; ar_size_i = 0; ar_burst_i = 0;
    r_ready_i = 0;

    repeat (2) @(posedge clk_i);
    #2;
    check("rst_outs", 128'(outs_vec), 128'(0));
    check("rst_rdata", r_data_o, 128'(0));
    check("rst_wdata_user", 128'({mem_wdata_o[95:0], r_user_o}), 128'(0));
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // single write, then read back
    send_aw(4'h3, 64'h8000_0010, 8'd0, INCR);
    w_beat(D_A5, 16'hFFFF, 1'b1, 1, 12'd1);
    get_b(4'h3, OKAY);
    send_ar(4'h7, 64'h8000_0010, 8'd0, INCR);
    get_r(4'h7, D_A5, OKAY, 1'b1, 0, 1'b1, 12'd1);

    // INCR burst with partial strobe on beat 2, then read back
    send_aw(4'h2, 64'h8000_0000, 8'd3, INCR);
    for (int k = 0; k < 4; k++) begin
      dk = {4{32'h1111_1111 * 32'(k + 1)}};
      w_beat(dk, (k == 2) ? 16'h00FF : 16'hFFFF, k == 3, 1, 12'(k));
    end
    get_b(4'h2, OKAY);
    send_ar(4'h2, 64'h8000_0000, 8'd3, INCR);
    for (int k = 0; k < 4; k++) begin
      dk = (k == 2) ? D_MERGED : {4{32'h1111_1111 * 32'(k + 1)}};
      get_r(4'h2, dk, OKAY, k == 3, 0, 1'b1, 12'(k));
    end

    // WRAP bursts: no SRAM access, SLVERR
    send_aw(4'h4, 64'h8000_0040, 8'd1, WRAP);
    w_beat(D_5A, 16'hFFFF, 1'b0, 0, 12'd0);
    w_beat(D_5A, 16'hFFFF, 1'b1, 0, 12'd0);
    get_b(4'h4, SLVERR);
    send_ar(4'h4, 64'h8000_0040, 8'd0, WRAP);
    get_r(4'h4, 128'(0), SLVERR, 1'b1, 0, 1'b0, 12'd0);

    // read crossing the end of the SRAM: per-beat error
    send_ar(4'h9, 64'h8000_FFF0, 8'd1, INCR);
    get_r(4'h9, {4{32'hC0DE_0FFF}}, OKAY, 1'b0, 0, 1'b1, 12'hFFF);
    get_r(4'h9, 128'(0), SLVERR, 1'b1, 0, 1'b0, 12'd0);

    // write below the base address
    send_aw(4'h1, 64'h7FFF_FFF0, 8'd0, INCR);
    w_beat(D_A5, 16'hFFFF, 1'b1, 0, 12'd0);
    get_b(4'h1, SLVERR);

    // both channels held valid, last served was a write: read, write, read, write
    aw_valid_i = 1'b1; aw_id_i = 4'h5; aw_addr_i = 64'h8000_0100; aw_len_i = 8'd0;
    aw_size_i = 3'd4; aw_burst_i = INCR;
    ar_valid_i = 1'b1; ar_id_i = 4'h6; ar_addr_i = 64'h8000_0000; ar_len_i = 8'd0;
    ar_size_i = 3'd4; ar_burst_i = INCR;
    for (int n = 0; n < 2; n++) begin
      #1;
      check("arb_rd_first", 128'({aw_ready_o, ar_ready_o}), 128'(2'b01));
      @(posedge clk_i); #1;
      get_r(4'h6, {4{32'h1111_1111}}, OKAY, 1'b1, 0, 1'b1, 12'd0);
      #1;
      check("arb_wr_next", 128'({aw_ready_o, ar_ready_o}), 128'(2'b10));
      @(posedge clk_i); #1;
      w_beat(D_5A, 16'hFFFF, 1'b1, 1, 12'h010);
      get_b(4'h5, OKAY);
    end
    aw_valid_i = 1'b0; ar_valid_i = 1'b0;

    // R backpressure: 3 stalled cycles per beat
    send_ar(4'h8, 64'h8000_0000, 8'd1, INCR);
    get_r(4'h8, {4{32'h1111_1111}}, OKAY, 1'b0, 3, 1'b1, 12'd0);
    get_r(4'h8, {4{32'h2222_2222}}, OKAY, 1'b1, 3, 1'b1, 12'd1);

    // early w_last: all 3 beats still consumed, SLVERR
    send_aw(4'hA, 64'h8000_0200, 8'd2, INCR);
    w_beat(D_A5, 16'hFFFF, 1'b0, 1, 12'h020);
    w_beat(D_A5, 16'hFFFF, 1'b1, -1, 12'd0);
    w_beat(D_A5, 16'hFFFF, 1'b0, -1, 12'd0);
    get_b(4'hA, SLVERR);

    // reset in the middle of a read burst
    send_ar(4'hC, 64'h8000_0000, 8'd3, INCR);
    get_r(4'hC, {4{32'h1111_1111}}, OKAY, 1'b0, 0, 1'b1, 12'd0);
    #1;
    check("pre_rst_req", 128'(mem_req_o), 128'(1));
    rst_ni = 1'b0;
    #1;
    check("rst_async_outs", 128'(outs_vec), 128'(0));
    check("rst_async_rdata", r_data_o, 128'(0));
    @(posedge clk_i); #2;
    check("rst_held_outs", 128'(outs_vec), 128'(0));
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    send_ar(4'hD, 64'h8000_0200, 8'd0, INCR);
    get_r(4'hD, D_A5, OKAY, 1'b1, 0, 1'b1, 12'h020);

    check("readies_never_both", 128'(both_rdy), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
